// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// This file holds the state encoding, the hardwired-zero register number and the counter width.
package hazard_pkg;

    localparam int         CNT_W    = 16;
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Larger of two stall lengths, used when load-use and flag hazards coincide
    function automatic logic [2:0] max_cyc(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter.
// It counts up by one on each clock edge where inc is high and stops at all-ones.
module sat_counter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [N-1:0] count
);

    localparam logic [N-1:0] MAX_VAL = {N{1'b1}};
    localparam logic [N-1:0] ONE_VAL = N'(1);

    // Count register; holds at the maximum instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + ONE_VAL;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / flag hazard stall controller with branch flush and stall/flush statistics.
// The stall and flush controls are combinational; the state and counters are registered.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LD_STALL_CYC   = 1,
    parameter int FLAG_STALL_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       DecRn,
    input  logic [4:0]       DecRm,
    input  logic             DecUsesRn,
    input  logic             DecUsesRm,
    input  logic             DecIsCondBr,
    input  logic [4:0]       ExAw,
    input  logic             ExMemRead,
    input  logic             ExRegWrite,
    input  logic             ExFlagWrite,
    input  logic             ExBrTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [2:0] LD_N   = 3'(LD_STALL_CYC);
    localparam logic [2:0] FLAG_N = 3'(FLAG_STALL_CYC);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] rem_r;
    logic [2:0] rem_nxt_s;
    logic [2:0] n_sel_s;
    logic       ld_haz_s;
    logic       flag_haz_s;
    logic       pc_write_s;
    logic       ifid_write_s;
    logic       ifid_flush_s;
    logic       idex_flush_s;

    // A load writing r31 never creates a dependence, since r31 reads as zero
    assign ld_haz_s = ExMemRead && ExRegWrite && (ExAw != ZERO_REG) &&
                      ((DecUsesRn && (DecRn == ExAw)) || (DecUsesRm && (DecRm == ExAw)));
    assign flag_haz_s = DecIsCondBr && ExFlagWrite;

    // Stall length for the hazard detected this cycle
    always_comb begin
        n_sel_s = FLAG_N;
        if (ld_haz_s && flag_haz_s) begin
            n_sel_s = max_cyc(LD_N, FLAG_N);
        end else if (ld_haz_s) begin
            n_sel_s = LD_N;
        end else begin
            n_sel_s = FLAG_N;
        end
    end

    // Pipeline control decode and next-state logic; a taken branch wins over everything
    always_comb begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        state_nxt_s  = state_r;
        rem_nxt_s    = rem_r;
        if (!reset) begin
            state_nxt_s = RUN;
            rem_nxt_s   = 3'd0;
        end else if (ExBrTaken) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
            state_nxt_s  = RUN;
            rem_nxt_s    = 3'd0;
        end else if (state_r == STALL) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
            if (rem_r <= 3'd1) begin
                state_nxt_s = RUN;
                rem_nxt_s   = 3'd0;
            end else begin
                state_nxt_s = STALL;
                rem_nxt_s   = rem_r - 3'd1;
            end
        end else if (ld_haz_s || flag_haz_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
            rem_nxt_s    = n_sel_s - 3'd1;
            if (n_sel_s > 3'd1) begin
                state_nxt_s = STALL;
            end else begin
                state_nxt_s = RUN;
            end
        end else begin
            state_nxt_s = RUN;
            rem_nxt_s   = 3'd0;
        end
    end

    // State and remaining-cycle registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
            rem_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
        end
    end

    assign PCWrite   = pc_write_s;
    assign IFIDWrite = ifid_write_s;
    assign IFIDFlush = ifid_flush_s;
    assign IDEXFlush = idex_flush_s;

    sat_counter #(.N(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_write_s),
        .count (StallCount)
    );

    sat_counter #(.N(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ExBrTaken),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with default stall lengths (a_*),
// one with LD_STALL_CYC=3, FLAG_STALL_CYC=2 (b_*), both driven by the same inputs.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  DecRn, DecRm, ExAw;
    logic        DecUsesRn, DecUsesRm, DecIsCondBr;
    logic        ExMemRead, ExRegWrite, ExFlagWrite, ExBrTaken;

    logic        a_pc, a_ifidw, a_ifidf, a_idexf;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_ifidw, b_ifidf, b_idexf;
    logic [15:0] b_stall, b_flush;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut_a (
        .clk(clk), .reset(reset),
        .DecRn(DecRn), .DecRm(DecRm), .DecUsesRn(DecUsesRn), .DecUsesRm(DecUsesRm),
        .DecIsCondBr(DecIsCondBr), .ExAw(ExAw), .ExMemRead(ExMemRead),
        .ExRegWrite(ExRegWrite), .ExFlagWrite(ExFlagWrite), .ExBrTaken(ExBrTaken),
        .PCWrite(a_pc), .IFIDWrite(a_ifidw), .IFIDFlush(a_ifidf), .IDEXFlush(a_idexf),
        .StallCount(a_stall), .FlushCount(a_flush)
    );

    hazard_ctrl #(.LD_STALL_CYC(3), .FLAG_STALL_CYC(2)) dut_b (
        .clk(clk), .reset(reset),
        .DecRn(DecRn), .DecRm(DecRm), .DecUsesRn(DecUsesRn), .DecUsesRm(DecUsesRm),
        .DecIsCondBr(DecIsCondBr), .ExAw(ExAw), .ExMemRead(ExMemRead),
        .ExRegWrite(ExRegWrite), .ExFlagWrite(ExFlagWrite), .ExBrTaken(ExBrTaken),
        .PCWrite(b_pc), .IFIDWrite(b_ifidw), .IFIDFlush(b_ifidf), .IDEXFlush(b_idexf),
        .StallCount(b_stall), .FlushCount(b_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        DecRn = 5'd0; DecRm = 5'd0; ExAw = 5'd0;
        DecUsesRn = 1'b0; DecUsesRm = 1'b0; DecIsCondBr = 1'b0;
        ExMemRead = 1'b0; ExRegWrite = 1'b0; ExFlagWrite = 1'b0; ExBrTaken = 1'b0;
    endtask

    task automatic load_use_rn5();
        clear_in();
        ExMemRead = 1'b1; ExRegWrite = 1'b1; ExAw = 5'd5;
        DecUsesRn = 1'b1; DecRn = 5'd5;
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        reset = 1'b0;
        #2;
        chk("rst_a_pc", 32'(a_pc), 32'd1);
        chk("rst_a_idexf", 32'(a_idexf), 32'd0);
        chk("rst_a_stall", 32'(a_stall), 32'd0);
        chk("rst_b_flush", 32'(b_flush), 32'd0);
        // Hazard inputs while in reset must not stall
        load_use_rn5();
        #1;
        chk("rst_haz_a_pc", 32'(a_pc), 32'd1);
        chk("rst_haz_a_ifidw", 32'(a_ifidw), 32'd1);
        chk("rst_haz_b_idexf", 32'(b_idexf), 32'd0);
        clear_in();
        #5 reset = 1'b1;

        // Load-use: 1 stall cycle on a, 3 on b
        edge1();
        load_use_rn5();
        #1;
        chk("ld_a_pc", 32'(a_pc), 32'd0);
        chk("ld_a_ifidw", 32'(a_ifidw), 32'd0);
        chk("ld_a_idexf", 32'(a_idexf), 32'd1);
        chk("ld_a_ifidf", 32'(a_ifidf), 32'd0);
        chk("ld_b_pc1", 32'(b_pc), 32'd0);
        edge1();
        clear_in();
        #1;
        chk("ld_a_pc_after", 32'(a_pc), 32'd1);
        chk("ld_a_idexf_after", 32'(a_idexf), 32'd0);
        chk("ld_a_stall", 32'(a_stall), 32'd1);
        chk("ld_b_pc2", 32'(b_pc), 32'd0);
        chk("ld_b_idexf2", 32'(b_idexf), 32'd1);
        edge1();
        #1;
        chk("ld_b_pc3", 32'(b_pc), 32'd0);
        chk("ld_b_stall2", 32'(b_stall), 32'd2);
        edge1();
        #1;
        chk("ld_b_pc4", 32'(b_pc), 32'd1);
        chk("ld_b_stall3", 32'(b_stall), 32'd3);
        chk("ld_a_stall_hold", 32'(a_stall), 32'd1);

        // Zero register is never a hazard source
        ExMemRead = 1'b1; ExRegWrite = 1'b1; ExAw = 5'd31;
        DecUsesRn = 1'b1; DecRn = 5'd31;
        #1;
        chk("zr_a_pc", 32'(a_pc), 32'd1);
        chk("zr_b_pc", 32'(b_pc), 32'd1);
        edge1();
        clear_in();
        #1;
        chk("zr_a_stall", 32'(a_stall), 32'd1);
        chk("zr_b_stall", 32'(b_stall), 32'd3);

        // Rm match without RegWrite is no hazard; with RegWrite it is
        ExMemRead = 1'b1; ExRegWrite = 1'b0; ExAw = 5'd7;
        DecUsesRm = 1'b1; DecRm = 5'd7;
        #1;
        chk("rm_nowr_a_pc", 32'(a_pc), 32'd1);
        ExRegWrite = 1'b1;
        #1;
        chk("rm_a_pc", 32'(a_pc), 32'd0);
        chk("rm_b_pc", 32'(b_pc), 32'd0);
        edge1();
        clear_in();
        #1;
        chk("rm_a_stall", 32'(a_stall), 32'd2);
        chk("rm_b_pc2", 32'(b_pc), 32'd0);
        edge1();
        edge1();
        #1;
        chk("rm_b_pc_run", 32'(b_pc), 32'd1);
        chk("rm_b_stall", 32'(b_stall), 32'd6);

        // Flag hazard, then taken branch on the 2nd cycle of b's stall
        DecIsCondBr = 1'b1; ExFlagWrite = 1'b1;
        #1;
        chk("fl_a_pc", 32'(a_pc), 32'd0);
        chk("fl_b_pc", 32'(b_pc), 32'd0);
        chk("fl_b_idexf", 32'(b_idexf), 32'd1);
        edge1();
        ExBrTaken = 1'b1;
        #1;
        chk("br_b_pc", 32'(b_pc), 32'd1);
        chk("br_b_ifidw", 32'(b_ifidw), 32'd1);
        chk("br_b_ifidf", 32'(b_ifidf), 32'd1);
        chk("br_b_idexf", 32'(b_idexf), 32'd1);
        chk("br_a_ifidf", 32'(a_ifidf), 32'd1);
        edge1();
        clear_in();
        #1;
        chk("br_b_run_pc", 32'(b_pc), 32'd1);
        chk("br_b_run_ifidf", 32'(b_ifidf), 32'd0);
        chk("br_b_flush", 32'(b_flush), 32'd1);
        chk("br_a_flush", 32'(a_flush), 32'd1);
        chk("br_b_stall", 32'(b_stall), 32'd7);
        chk("br_a_stall", 32'(a_stall), 32'd3);

        // Asynchronous reset mid-stall on b
        load_use_rn5();
        edge1();
        clear_in();
        #1;
        chk("ar_b_pc_stall", 32'(b_pc), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("ar_b_pc", 32'(b_pc), 32'd1);
        chk("ar_b_idexf", 32'(b_idexf), 32'd0);
        chk("ar_b_stall", 32'(b_stall), 32'd0);
        chk("ar_b_flush", 32'(b_flush), 32'd0);
        chk("ar_a_stall", 32'(a_stall), 32'd0);
        #1 reset = 1'b1;
        edge1();
        #1;
        chk("ar_b_pc_rel", 32'(b_pc), 32'd1);
        edge1();
        #1;
        chk("ar_b_pc_rel2", 32'(b_pc), 32'd1);
        chk("ar_b_stall_rel", 32'(b_stall), 32'd0);

        // Saturation: 70000 consecutive stall cycles
        load_use_rn5();
        repeat (65534) edge1();
        chk("sat_a_fffe", 32'(a_stall), 32'h0000FFFE);
        repeat (4466) edge1();
        chk("sat_a_ffff", 32'(a_stall), 32'h0000FFFF);
        chk("sat_b_ffff", 32'(b_stall), 32'h0000FFFF);
        chk("sat_a_pc", 32'(a_pc), 32'd0);
        clear_in();
        repeat (3) edge1();
        chk("sat_a_hold", 32'(a_stall), 32'h0000FFFF);
        chk("sat_a_pc_run", 32'(a_pc), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
